// File: rtl/piano_pkg.sv
// piano_pkg: shared types and constants for the piano note scheduler.
//   state_e     - scheduler FSM states (IDLE, LOAD, PLAY, GAP)
//   NOTE_IDX_W  - width of a key / note index
//   NOTE_DIV    - buzzer half-period dividers for C4..C5 at a 50 MHz clock
//   note_div()  - divider lookup for any 4-bit note index
package piano_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam int NOTE_IDX_W = 4;
  localparam int NOTE_DIV_W = 20;
  localparam int NUM_NOTES  = 8;

  // C4 D4 E4 F4 G4 A4 B4 C5
  localparam logic [NOTE_DIV_W-1:0] NOTE_DIV [NUM_NOTES] = '{
    20'd95556, 20'd85131, 20'd75843, 20'd71586,
    20'd63776, 20'd56818, 20'd50619, 20'd47778
  };

  // Indices 8..15 (only reachable with a 16-key bank) reuse the table one
  // octave up: halving the half-period doubles the pitch.
  function automatic logic [NOTE_DIV_W-1:0] note_div(input logic [NOTE_IDX_W-1:0] idx);
    if (!idx[3]) return NOTE_DIV[idx[2:0]];
    else         return NOTE_DIV[idx[2:0]] >> 1;
  endfunction

endpackage

// File: rtl/key_priority_enc.sv
// key_priority_enc: combinational lowest-set-bit encoder for the key bank.
//   key_i   in  NUM_KEYS  key pressed flags, bit 0 has highest priority
//   idx_o   out IDX_W     index of the lowest set bit (0 when none set)
//   valid_o out 1         high when any key bit is set
module key_priority_enc #(
  parameter int NUM_KEYS = 8,
  parameter int IDX_W    = 4
) (
  input  logic [NUM_KEYS-1:0] key_i,
  output logic [IDX_W-1:0]    idx_o,
  output logic                valid_o
);

  // Scan from the top down so the lowest set bit is the last to write.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/piano_note_scheduler.sv
// piano_note_scheduler: arbitrates the key bank onto the single buzzer tone
// counter. Picks the lowest pressed key, loads its divider, enables the
// counter for at least MIN_HOLD cycles and inserts GAP_CYCLES of silence
// between notes.
//   clk          in  1           system clock
//   rst_n        in  1           synchronous reset, active HIGH (1 = reset)
//   key_i        in  NUM_KEYS    key pressed flags, bit 0 highest priority
//   mute_i       in  1           immediate stop request, overrides everything
//   div_o        out DIV_W       half-period divider for the buzzer counter
//   div_load_o   out 1           one-cycle reload pulse for the buzzer counter
//   counterE_o   out 1           buzzer counter enable
//   note_idx_o   out 4           index of the current or last note
//   busy_o       out 1           high whenever the scheduler is not IDLE
module piano_note_scheduler
  import piano_pkg::*;
#(
  parameter int NUM_KEYS   = 8,
  parameter int DIV_W      = 20,
  parameter int MIN_HOLD   = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_KEYS-1:0]   key_i,
  input  logic                  mute_i,
  output logic [DIV_W-1:0]      div_o,
  output logic                  div_load_o,
  output logic                  counterE_o,
  output logic [NOTE_IDX_W-1:0] note_idx_o,
  output logic                  busy_o
);

  localparam int HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [NOTE_IDX_W-1:0]   note_q, note_d;
  logic                    load_q, load_d;
  logic                    en_q, en_d;
  logic                    busy_q, busy_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [GAP_W-1:0]        gap_q, gap_d;

  logic [NOTE_IDX_W-1:0]   pick;
  logic                    any_key;
  logic [15:0]             key_ext;
  logic                    key_held;

  key_priority_enc #(
    .NUM_KEYS (NUM_KEYS),
    .IDX_W    (NOTE_IDX_W)
  ) u_enc (
    .key_i   (key_i),
    .idx_o   (pick),
    .valid_o (any_key)
  );

  // Widened so the latched 4-bit index can select a bit for any NUM_KEYS.
  assign key_ext  = 16'(key_i);
  assign key_held = key_ext[note_q];

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    note_d  = note_q;
    hold_d  = hold_q;
    gap_d   = '0;
    // Pulse and enable trail the state by one cycle: the reload pulse is seen
    // while the FSM sits in its first PLAY cycle, the enable one cycle later.
    load_d  = (state_q == ST_LOAD);
    en_d    = (state_q == ST_PLAY);

    unique case (state_q)
      ST_IDLE: begin
        if (any_key) begin
          state_d = ST_LOAD;
          note_d  = pick;
          div_d   = DIV_W'(note_div(pick));
        end
      end
      ST_LOAD: begin
        state_d = ST_PLAY;
        hold_d  = '0;
      end
      ST_PLAY: begin
        // Releases before the hold counter saturates are ignored; other
        // keys never pre-empt the latched note.
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end else if (!key_held) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q != GAP_LAST) begin
          gap_d = gap_q + 1'b1;
        end else if (any_key) begin
          state_d = ST_LOAD;
          note_d  = pick;
          div_d   = DIV_W'(note_div(pick));
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Mute wins over every transition; divider and note index are kept.
    if (mute_i) begin
      state_d = ST_IDLE;
      div_d   = div_q;
      note_d  = note_q;
      load_d  = 1'b0;
      en_d    = 1'b0;
      gap_d   = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      note_q  <= '0;
      load_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      note_q  <= note_d;
      load_q  <= load_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  assign div_o      = div_q;
  assign div_load_o = load_q;
  assign counterE_o = en_q;
  assign note_idx_o = note_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_piano_note_scheduler.sv
// Testbench for piano_note_scheduler: directed scenarios plus a randomized
// run, all checked against a cycle-level behavioural model of the note rules.
module tb_piano_note_scheduler;

  localparam int MIN_HOLD   = 4;
  localparam int GAP_CYCLES = 2;
  localparam int P_IDLE = 0, P_LOAD = 1, P_PLAY = 2, P_GAP = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  key_i = 8'h00;
  logic        mute_i = 1'b0;
  logic [19:0] div_o;
  logic        div_load_o;
  logic        counterE_o;
  logic [3:0]  note_idx_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  int note_table [8] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};

  // Behavioural model: phase, note being played, cycles spent in PLAY/GAP.
  int   m_phase  = P_IDLE;
  int   m_note   = 0;
  int   m_div    = 0;
  int   m_played = 0;
  int   m_gap    = 0;
  logic m_load   = 1'b0;
  logic m_en     = 1'b0;

  piano_note_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_i      (key_i),
    .mute_i     (mute_i),
    .div_o      (div_o),
    .div_load_o (div_load_o),
    .counterE_o (counterE_o),
    .note_idx_o (note_idx_o),
    .busy_o     (busy_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic int lowest_key(input logic [7:0] k);
    logic [7:0] iso;
    int p;
    iso = k & (~k + 8'd1);
    p = 0;
    for (int b = 0; b < 8; b++) if (iso[b]) p = b;
    return p;
  endfunction

  function automatic logic [26:0] exp_vec();
    return {20'(m_div), m_load, m_en, 4'(m_note), (m_phase != P_IDLE)};
  endfunction

  task automatic model_edge(input logic [7:0] k, input logic m, input logic r);
    if (r) begin
      m_phase = P_IDLE; m_note = 0; m_div = 0; m_played = 0; m_gap = 0;
      m_load = 1'b0; m_en = 1'b0;
      return;
    end
    m_load = (m_phase == P_LOAD) && !m;
    m_en   = (m_phase == P_PLAY) && !m;
    if (m) begin
      m_phase = P_IDLE;
      return;
    end
    case (m_phase)
      P_IDLE: if (k != 8'h00) begin
        m_note = lowest_key(k); m_div = note_table[m_note]; m_phase = P_LOAD;
      end
      P_LOAD: begin m_phase = P_PLAY; m_played = 0; end
      P_PLAY: begin
        m_played++;
        if (m_played >= MIN_HOLD && !k[m_note]) begin m_phase = P_GAP; m_gap = 0; end
      end
      default: begin
        m_gap++;
        if (m_gap == GAP_CYCLES) begin
          if (k != 8'h00) begin
            m_note = lowest_key(k); m_div = note_table[m_note]; m_phase = P_LOAD;
          end else begin
            m_phase = P_IDLE;
          end
        end
      end
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [7:0] k, input logic m, input logic r);
    key_i = k; mute_i = m; rst_n = r;
    @(posedge clk);
    model_edge(k, m, r);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      step(8'h01, 1'b0, 1'b1);
      n_cmp++;
      if ({div_o, div_load_o, counterE_o, note_idx_o, busy_o} !== 27'd0) begin
        n_err++;
        $display("FAIL reset_outputs cycle %0d: got %h want 0", c,
                 {div_o, div_load_o, counterE_o, note_idx_o, busy_o});
      end
    end
    step(8'h01, 1'b0, 1'b0);
    n_cmp++;
    if (div_o !== 20'd95556 || busy_o !== 1'b1 || div_load_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_load: div=%0d busy=%b load=%b want 95556/1/0",
               div_o, busy_o, div_load_o);
    end
    for (int c = 0; c < 8; c++) begin
      step(8'h00, 1'b0, 1'b0);
      n_cmp++;
      if ({div_o, div_load_o, counterE_o, note_idx_o, busy_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL reset_follow cycle %0d: got %h want %h", c,
                 {div_o, div_load_o, counterE_o, note_idx_o, busy_o}, exp_vec());
      end
    end
  endtask

  task automatic test_single_note();
    int loads, en_cycles;
    loads = 0; en_cycles = 0;
    step(8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 16; c++) begin
      step((c < 10) ? 8'h04 : 8'h00, 1'b0, 1'b0);
      loads += int'(div_load_o);
      en_cycles += int'(counterE_o);
      n_cmp++;
      if ({div_o, div_load_o, counterE_o, note_idx_o, busy_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL single_trace cycle %0d: got %h want %h", c,
                 {div_o, div_load_o, counterE_o, note_idx_o, busy_o}, exp_vec());
      end
      if (c == 5) begin
        n_cmp++;
        if (div_o !== 20'd75843 || note_idx_o !== 4'd2) begin
          n_err++;
          $display("FAIL single_note_div: div=%0d idx=%0d want 75843/2", div_o, note_idx_o);
        end
      end
    end
    n_cmp++;
    if (loads != 1) begin
      n_err++; $display("FAIL single_load_pulses: got %0d want 1", loads);
    end
    n_cmp++;
    if (en_cycles != 9) begin
      n_err++; $display("FAIL single_enable_cycles: got %0d want 9", en_cycles);
    end
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++; $display("FAIL single_back_idle: busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_short_press();
    int en_cycles;
    en_cycles = 0;
    step(8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 14; c++) begin
      step((c == 0) ? 8'h10 : 8'h00, 1'b0, 1'b0);
      en_cycles += int'(counterE_o);
      n_cmp++;
      if ({div_o, div_load_o, counterE_o, note_idx_o, busy_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL short_trace cycle %0d: got %h want %h", c,
                 {div_o, div_load_o, counterE_o, note_idx_o, busy_o}, exp_vec());
      end
    end
    n_cmp++;
    if (en_cycles != MIN_HOLD) begin
      n_err++; $display("FAIL short_enable_cycles: got %0d want %0d", en_cycles, MIN_HOLD);
    end
    n_cmp++;
    if (div_o !== 20'd63776) begin
      n_err++; $display("FAIL short_div: got %0d want 63776", div_o);
    end
  endtask

  task automatic test_priority();
    logic [7:0] k;
    int loads;
    loads = 0;
    step(8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 23; c++) begin
      k = (c < 3) ? 8'h60 : ((c < 9) ? 8'h61 : 8'h01);
      step(k, 1'b0, 1'b0);
      loads += int'(div_load_o);
      n_cmp++;
      if ({div_o, div_load_o, counterE_o, note_idx_o, busy_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL prio_trace cycle %0d: got %h want %h", c,
                 {div_o, div_load_o, counterE_o, note_idx_o, busy_o}, exp_vec());
      end
      if (c == 8) begin
        n_cmp++;
        if (note_idx_o !== 4'd5 || counterE_o !== 1'b1) begin
          n_err++;
          $display("FAIL prio_no_preempt: idx=%0d en=%b want 5/1", note_idx_o, counterE_o);
        end
      end
    end
    n_cmp++;
    if (note_idx_o !== 4'd0 || div_o !== 20'd95556 || counterE_o !== 1'b1 || loads != 2) begin
      n_err++;
      $display("FAIL prio_next_note: idx=%0d div=%0d en=%b loads=%0d want 0/95556/1/2",
               note_idx_o, div_o, counterE_o, loads);
    end
  endtask

  task automatic test_mute();
    step(8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) step(8'h02, 1'b0, 1'b0);
    n_cmp++;
    if (counterE_o !== 1'b1) begin
      n_err++; $display("FAIL mute_pre_play: en=%b want 1", counterE_o);
    end
    step(8'h02, 1'b1, 1'b0);
    n_cmp++;
    if (counterE_o !== 1'b0 || busy_o !== 1'b0 || div_load_o !== 1'b0 || div_o !== 20'd85131) begin
      n_err++;
      $display("FAIL mute_stop: en=%b busy=%b load=%b div=%0d want 0/0/0/85131",
               counterE_o, busy_o, div_load_o, div_o);
    end
    step(8'h02, 1'b0, 1'b0);
    n_cmp++;
    if (busy_o !== 1'b1 || div_load_o !== 1'b0) begin
      n_err++; $display("FAIL mute_restrike_load: busy=%b load=%b want 1/0", busy_o, div_load_o);
    end
    step(8'h02, 1'b0, 1'b0);
    n_cmp++;
    if (div_load_o !== 1'b1 || {div_o, div_load_o, counterE_o, note_idx_o, busy_o} !== exp_vec()) begin
      n_err++;
      $display("FAIL mute_restrike_pulse: got %h want %h",
               {div_o, div_load_o, counterE_o, note_idx_o, busy_o}, exp_vec());
    end
  endtask

  task automatic test_reset_mid_note();
    step(8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) step(8'h08, 1'b0, 1'b0);
    n_cmp++;
    if (counterE_o !== 1'b1 || div_o !== 20'd71586) begin
      n_err++; $display("FAIL midreset_pre: en=%b div=%0d want 1/71586", counterE_o, div_o);
    end
    step(8'h08, 1'b0, 1'b1);
    n_cmp++;
    if ({div_o, div_load_o, counterE_o, note_idx_o, busy_o} !== 27'd0) begin
      n_err++;
      $display("FAIL midreset_silence: got %h want 0",
               {div_o, div_load_o, counterE_o, note_idx_o, busy_o});
    end
  endtask

  task automatic test_random();
    logic [7:0] k;
    logic m, r;
    k = 8'h00;
    step(8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 4) == 0)
        k = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      m = ($urandom_range(0, 29) == 0);
      r = ($urandom_range(0, 149) == 0);
      step(k, m, r);
      n_cmp++;
      if ({div_o, div_load_o, counterE_o, note_idx_o, busy_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL random cycle %0d key=%h mute=%b rst=%b: got %h want %h", c, k, m, r,
                 {div_o, div_load_o, counterE_o, note_idx_o, busy_o}, exp_vec());
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    #2;
    test_reset();
    test_single_note();
    test_short_press();
    test_priority();
    test_mute();
    test_reset_mid_note();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piano_note_scheduler.md
Name: piano_note_scheduler

Overview:
- Arbitrates a bank of piano key inputs onto the single buzzer tone counter.
- Selects one key by fixed priority and loads that note's half-period divider into the counter, then gates the counter enable.
- Enforces a minimum note duration and a silent gap between consecutive notes.
- Sits between the debounced key inputs and the buzzer counter in the piano top level.

Parameters:
- NUM_KEYS, 8, number of key requesters (maximum 16).
- DIV_W, 20, width of the divider value driven to the buzzer counter.
- MIN_HOLD, 4, minimum PLAY cycles per note (must be at least 1).
- GAP_CYCLES, 2, silent cycles between notes (must be at least 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-high reset (1 = reset).
- key_i  in  NUM_KEYS  key pressed flags; bit 0 has highest priority.
- mute_i  in  1  immediate stop request.
- div_o  out  DIV_W  half-period divider for the buzzer counter.
- div_load_o  out  1  one-cycle pulse that reloads the buzzer counter with div_o.
- counterE_o  out  1  buzzer counter enable.
- note_idx_o  out  4  index of the current or last note.
- busy_o  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst_n=1 at a clk edge): state=IDLE; div_o=0; div_load_o=0; counterE_o=0; note_idx_o=0; busy_o=0; hold and gap counters=0. Reset mid-note silences the buzzer on the next edge.
- States: IDLE, LOAD, PLAY, GAP. All outputs are registered.
- pick = index of the lowest set bit of key_i. "any" = OR of all key_i bits.
- IDLE:
  - counterE_o=0.
  - If any and not mute_i: latch idx=pick, note_idx_o=pick, div_o=NOTE_DIV[pick]; go to LOAD.
- LOAD:
  - Exactly one cycle. div_load_o=1, counterE_o=0, hold counter cleared.
  - Next state is PLAY.
- PLAY:
  - counterE_o=1; the hold counter increments each cycle and saturates at MIN_HOLD-1.
  - Exit to GAP when the hold counter = MIN_HOLD-1 and key_i[idx]=0.
  - A release earlier than that is ignored until MIN_HOLD is reached.
  - Higher-priority keys pressed during PLAY do not pre-empt the current note.
  - Holding key_i[idx] keeps PLAY indefinitely.
- GAP:
  - counterE_o=0; the gap counter runs for GAP_CYCLES cycles.
  - On the last gap cycle: if any, latch a new pick and go to LOAD (re-striking the same key is allowed); otherwise go to IDLE.
- mute_i=1 in any state: next state is IDLE, counterE_o=0, div_load_o=0. mute_i overrides all other transitions. div_o and note_idx_o hold their values.
- Latency:
  - Key press sampled in IDLE at edge N: div_load_o=1 after edge N+1, counterE_o=1 after edge N+2.
  - Release: counterE_o falls one cycle after the release is sampled, once MIN_HOLD is satisfied.
- Simultaneous keys: the lowest index wins. Key bits at or above NUM_KEYS do not exist.
- div_o changes only in the cycle the state enters LOAD, so it is stable whenever counterE_o=1.

Decomposition:
- piano_pkg holds:
  - state enum (IDLE, LOAD, PLAY, GAP);
  - NOTE_DIV constant array for a 50 MHz clock: C4 95556, D4 85131, E4 75843, F4 71586, G4 63776, A4 56818, B4 50619, C5 47778;
  - NOTE_IDX_W=4.
- One sub-module, key_priority_enc: combinational lowest-set-bit encoder producing an index and a valid flag. The FSM, counters and output registers stay in the top module.

Test Plan:
- Reset: hold rst_n=1 for 3 cycles with key_i=8'h01 → all outputs 0, state IDLE. Release reset → LOAD next edge with div_o=95556.
- Single note: key_i=8'h04 for 10 cycles, then 0 → div_o=75843, note_idx_o=2, one div_load_o pulse, counterE_o high until one cycle after release, then low for 2 GAP cycles, then IDLE.
- Short press: key_i=8'h10 for 1 cycle → counterE_o high for exactly MIN_HOLD=4 cycles, div_o=63776.
- Priority and no pre-empt: key_i=8'h60, then 8'h61 during PLAY → note_idx_o stays 5. After key 5 releases and the GAP ends, the next note is index 0 with div_o=95556.
- Mute: mute_i=1 for 1 cycle mid-PLAY → counterE_o=0 next edge, busy_o=0, no div_load_o pulse. With a key still held after mute drops, LOAD occurs on the following edge.
- Reset mid-note: rst_n=1 during PLAY → counterE_o=0, div_o=0 next edge.
